// File: rtl/dma_tx_arb.sv
// rtl/dma_tx_arb.sv - N-channel packet arbiter feeding the PCIe RQ stream
module dma_tx_arb #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 128,
  parameter int KEEP_W   = 4,
  parameter int USER_W   = 60,
  parameter int DEPTH    = 512,
  parameter int ARB_MODE = 1,
  localparam int GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   s_tdata,
  input  logic [NUM_CH*USER_W-1:0]   s_tuser,
  input  logic [NUM_CH*KEEP_W-1:0]   s_tkeep,
  input  logic [NUM_CH-1:0]          s_tlast,
  input  logic [NUM_CH-1:0]          s_tvalid,
  output logic [NUM_CH-1:0]          s_tready,
  output logic [DATA_W-1:0]          s_axis_rq_tdata,
  output logic [USER_W-1:0]          s_axis_rq_tuser,
  output logic [KEEP_W-1:0]          s_axis_rq_tkeep,
  output logic                       s_axis_rq_tlast,
  output logic                       s_axis_rq_tvalid,
  input  logic                       s_axis_rq_tready,
  output logic [GW-1:0]              grant_idx,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 1 + USER_W + KEEP_W + DATA_W;

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  logic [EW-1:0]     head [NUM_CH];
  logic [EW-1:0]     sel_head;
  logic              out_pop;

  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    logic          in_v_q, in_v_d;
    logic [EW-1:0] in_q, in_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic [EW-1:0] mem [DEPTH];
    logic          acc;

    assign acc = s_tvalid[i] & rdy_q;

    // Ready lags the count by one edge and the input register adds one more beat;
    // the DEPTH-4 threshold leaves room for both.
    always_comb begin
      in_v_d = acc;
      in_d   = in_q;
      if (acc) begin
        in_d = {s_tlast[i], s_tuser[i*USER_W +: USER_W],
                s_tkeep[i*KEEP_W +: KEEP_W], s_tdata[i*DATA_W +: DATA_W]};
      end
      wptr_d = wptr_q + AW'(in_v_q);
      rptr_d = rptr_q + AW'(pop[i]);
      cnt_d  = cnt_q + CW'(in_v_q) - CW'(pop[i]);
      rdy_d  = ~(cnt_q >= CW'(DEPTH - 4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        in_v_q <= 1'b0;
        in_q   <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        rdy_q  <= 1'b0;
      end else begin
        in_v_q <= in_v_d;
        in_q   <= in_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
        rdy_q  <= rdy_d;
      end
    end

    always_ff @(posedge clk) begin
      if (in_v_q) mem[wptr_q] <= in_q;
    end

    assign empty[i]    = (cnt_q == '0);
    assign head[i]     = mem[rptr_q];
    assign s_tready[i] = rdy_q;
  end

  logic          found;
  logic [GW-1:0] win;
  logic [GW-1:0] cand_g;
  int            cand;

  always_comb begin
    found  = 1'b0;
    win    = '0;
    cand   = 0;
    cand_g = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand   = (ARB_MODE == 0) ? k : (int'(last_q) + 1 + k) % NUM_CH;
      cand_g = GW'(cand);
      if (!found && !empty[cand_g]) begin
        found = 1'b1;
        win   = cand_g;
      end
    end
  end

  assign sel_head         = head[grant_q];
  assign s_axis_rq_tvalid = (state_q == XFER) && !empty[grant_q];
  assign out_pop          = s_axis_rq_tvalid && s_axis_rq_tready;

  always_comb begin
    pop = '0;
    if (out_pop) pop[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          grant_d = win;
          last_d  = win;
        end
      end
      XFER: begin
        // Grant is held through mid-packet underrun; only the popped tlast releases it.
        if (out_pop && sel_head[EW-1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign s_axis_rq_tlast = sel_head[EW-1];
  assign s_axis_rq_tuser = sel_head[DATA_W+KEEP_W +: USER_W];
  assign s_axis_rq_tkeep = sel_head[DATA_W +: KEEP_W];
  assign s_axis_rq_tdata = sel_head[DATA_W-1:0];
  assign grant_idx       = grant_q;
  assign busy            = (state_q == XFER);

endmodule

// File: tb/tb_dma_tx_arb.sv
// tb/tb_dma_tx_arb.sv - randomized bench for dma_tx_arb against a queue-based reference model
module tb_dma_tx_arb;
  localparam int NCH = 4, DW = 64, KW = 2, UW = 8, DEPTH = 16, ARB = 1, GW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH*DW-1:0] s_tdata = '0;
  logic [NCH*UW-1:0] s_tuser = '0;
  logic [NCH*KW-1:0] s_tkeep = '0;
  logic [NCH-1:0]    s_tlast = '0;
  logic [NCH-1:0]    s_tvalid = '0;
  logic [NCH-1:0]    s_tready;
  logic [DW-1:0]     s_axis_rq_tdata;
  logic [UW-1:0]     s_axis_rq_tuser;
  logic [KW-1:0]     s_axis_rq_tkeep;
  logic              s_axis_rq_tlast;
  logic              s_axis_rq_tvalid;
  logic              s_axis_rq_tready = 1'b0;
  logic [GW-1:0]     grant_idx;
  logic              busy;

  dma_tx_arb #(.NUM_CH(NCH), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW),
               .DEPTH(DEPTH), .ARB_MODE(ARB)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_axis_rq_tdata(s_axis_rq_tdata), .s_axis_rq_tuser(s_axis_rq_tuser),
    .s_axis_rq_tkeep(s_axis_rq_tkeep), .s_axis_rq_tlast(s_axis_rq_tlast),
    .s_axis_rq_tvalid(s_axis_rq_tvalid), .s_axis_rq_tready(s_axis_rq_tready),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          l;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } beat_t;

  beat_t tx_q   [NCH][$];
  beat_t m_fifo [NCH][$];
  beat_t pend_b [NCH];
  bit    pend_v [NCH];
  bit    m_ready[NCH];
  bit    m_xfer;
  int    m_grant, m_last;
  bit    acc_v  [NCH];
  beat_t acc_b  [NCH];
  bit    m_pop;
  int    vprob, rq_prob, cyc;
  int    order_q[$];
  int    obs_pops;
  int    acc_cnt[NCH];
  int    n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_tvalid();
    return m_xfer && (m_fifo[m_grant].size() > 0);
  endfunction

  function automatic bit model_empty();
    bit e = !m_xfer;
    for (int i = 0; i < NCH; i++)
      if (tx_q[i].size() != 0 || m_fifo[i].size() != 0 || pend_v[i]) e = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_fifo[i].delete();
      tx_q[i].delete();
      pend_v[i]  = 1'b0;
      m_ready[i] = 1'b0;
    end
    m_xfer  = 1'b0;
    m_grant = 0;
    m_last  = NCH - 1;
  endtask

  // One clock of the reference: ready from the old occupancy, pop or arbitrate, then land last cycle's accepts.
  task automatic model_advance();
    bit    nr[NCH];
    bit    found;
    beat_t b;
    int    c;
    for (int i = 0; i < NCH; i++) nr[i] = m_fifo[i].size() < DEPTH - 4;
    if (m_pop) begin
      b = m_fifo[m_grant].pop_front();
      if (b.l) m_xfer = 1'b0;
    end else if (!m_xfer) begin
      found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        c = (ARB != 0) ? (m_last + 1 + k) % NCH : k;
        if (!found && m_fifo[c].size() > 0) begin
          found   = 1'b1;
          m_grant = c;
          m_last  = c;
          m_xfer  = 1'b1;
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (pend_v[i]) m_fifo[i].push_back(pend_b[i]);
      pend_v[i] = acc_v[i];
      pend_b[i] = acc_b[i];
      chk("fifo_overflow", 64'(m_fifo[i].size() <= DEPTH), 64'd1);
      m_ready[i] = nr[i];
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] er;
    beat_t h;
    for (int i = 0; i < NCH; i++) er[i] = m_ready[i];
    chk("s_tready", 64'(s_tready), 64'(er));
    chk("tvalid", 64'(s_axis_rq_tvalid), 64'(m_tvalid()));
    chk("busy", 64'(busy), 64'(m_xfer));
    chk("grant_idx", 64'(grant_idx), 64'(m_grant));
    if (m_tvalid()) begin
      h = m_fifo[m_grant][0];
      chk("tdata", s_axis_rq_tdata, h.d);
      chk("tuser", 64'(s_axis_rq_tuser), 64'(h.u));
      chk("tkeep", 64'(s_axis_rq_tkeep), 64'(h.k));
      chk("tlast", 64'(s_axis_rq_tlast), 64'(h.l));
    end
  endtask

  task automatic check_reset();
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_tvalid", 64'(s_axis_rq_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
  endtask

  task automatic step();
    for (int i = 0; i < NCH; i++) begin
      if (tx_q[i].size() > 0 && $urandom_range(99) < vprob) begin
        s_tvalid[i]           = 1'b1;
        s_tdata[i*DW +: DW]   = tx_q[i][0].d;
        s_tuser[i*UW +: UW]   = tx_q[i][0].u;
        s_tkeep[i*KW +: KW]   = tx_q[i][0].k;
        s_tlast[i]            = tx_q[i][0].l;
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
    s_axis_rq_tready = ($urandom_range(99) < rq_prob);
    for (int i = 0; i < NCH; i++) begin
      acc_v[i] = s_tvalid[i] && m_ready[i];
      acc_b[i] = '0;
      if (acc_v[i]) begin
        acc_b[i] = tx_q[i].pop_front();
        acc_cnt[i]++;
      end
    end
    m_pop = m_tvalid() && s_axis_rq_tready;
    if (s_axis_rq_tvalid && s_axis_rq_tready) begin
      obs_pops++;
      if (s_axis_rq_tlast) order_q.push_back(int'(grant_idx));
    end
    @(posedge clk);
    #1;
    cyc++;
    model_advance();
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    s_tvalid = '0;
    model_reset();
    #1;
    check_reset();
    repeat (n) begin
      @(posedge clk);
      #1;
      check_reset();
    end
    rst_n = 1'b1;
  endtask

  task automatic add_pkt(input int ch, input int len, input bit fixed, input bit close);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = fixed ? 64'(k + 1) : {$urandom(), $urandom()};
      b.u = UW'($urandom());
      b.k = KW'($urandom());
      b.l = close && (k == len - 1);
      tx_q[ch].push_back(b);
    end
  endtask

  task automatic drain();
    int guard = 0;
    vprob   = 100;
    rq_prob = 100;
    while (!model_empty() && guard < 500) begin
      step();
      guard++;
    end
    chk("drain_done", 64'(model_empty()), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int       n0;
    logic [7:0] tvh, tlh;
    n_chk = 0; n_fail = 0; cyc = 0; obs_pops = 0;
    vprob = 100; rq_prob = 100;
    for (int i = 0; i < NCH; i++) acc_cnt[i] = 0;

    do_reset(5);
    step();
    chk("tready_after_release", 64'(s_tready), 64'hF);
    repeat (3) step();

    // Latency: 4-beat packet 0x1..0x4 on ch0
    add_pkt(0, 4, 1'b1, 1'b1);
    n0 = -1; tvh = '0; tlh = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (n0 < 0 && tx_q[0].size() == 3) n0 = cyc - 1;
      if (n0 >= 0 && (cyc - n0) < 8) begin
        tvh[cyc - n0] = s_axis_rq_tvalid;
        tlh[cyc - n0] = s_axis_rq_tvalid && s_axis_rq_tlast;
      end
    end
    chk("latency_tvalid_window", 64'(tvh), 64'h78);
    chk("latency_tlast_cycle", 64'(tlh), 64'h40);
    drain();

    // Arbitration order over a preloaded set of 2-beat packets
    do_reset(2);
    order_q.delete();
    rq_prob = 0;
    for (int ch = 0; ch < NCH; ch++)
      for (int p = 0; p < 3; p++) add_pkt(ch, 2, 1'b0, 1'b1);
    repeat (12) step();
    drain();
    chk("arb_pkt_count", 64'(order_q.size()), 64'd12);
    for (int k = 0; k < 12 && k < order_q.size(); k++)
      chk("arb_order", 64'(order_q[k]), 64'((ARB != 0) ? (k % NCH) : (k / 3)));

    // Grant lock across a mid-packet underrun on ch0
    order_q.delete();
    add_pkt(0, 2, 1'b0, 1'b0);
    step(); step();
    add_pkt(1, 3, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      step();
      if (c >= 6) begin
        chk("lock_grant", 64'(grant_idx), 64'd0);
        chk("lock_tvalid", 64'(s_axis_rq_tvalid), 64'd0);
      end
    end
    add_pkt(0, 2, 1'b0, 1'b1);
    drain();
    chk("lock_pkt_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) begin
      chk("lock_first", 64'(order_q[0]), 64'd0);
      chk("lock_second", 64'(order_q[1]), 64'd1);
    end

    // Backpressure: ch1 streams into a stalled output
    rq_prob = 0;
    acc_cnt[1] = 0;
    for (int p = 0; p < 5; p++) add_pkt(1, 8, 1'b0, 1'b1);
    repeat (30) step();
    chk("bp_accepted", 64'(acc_cnt[1]), 64'(DEPTH - 2));
    chk("bp_tready_low", 64'(s_tready[1]), 64'd0);
    obs_pops = 0;
    drain();
    chk("bp_drained", 64'(obs_pops), 64'd40);

    // Reset while beat 3 of an 8-beat packet is presented
    add_pkt(2, 8, 1'b0, 1'b1);
    repeat (5) step();
    chk("mid_tvalid_before", 64'(s_axis_rq_tvalid), 64'd1);
    do_reset(3);
    repeat (4) step();
    add_pkt(2, 8, 1'b0, 1'b1);
    obs_pops = 0;
    drain();
    chk("mid_after_pops", 64'(obs_pops), 64'd8);

    // Random traffic
    vprob = 70;
    rq_prob = 60;
    for (int c = 0; c < 1500; c++) begin
      int ch;
      ch = int'($urandom_range(NCH - 1));
      if (tx_q[ch].size() < 4) add_pkt(ch, int'($urandom_range(1, 6)), 1'b0, 1'b1);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
